// File: rtl/wb_arbiter2.sv
// Two-master / one-slave Wishbone arbiter: round-robin grant, CYC-locked, one IDLE turnaround cycle.
// Define WB_ARB_TIMEOUT_EN to add a slave-response watchdog of TIMEOUT_CYCLES stalled strobe cycles.
module wb_arbiter2 #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            M0_CYC_I,
  input  logic            M0_STB_I,
  input  logic            M0_WE_I,
  input  logic [DW/8-1:0] M0_SEL_I,
  input  logic [AW-1:0]   M0_ADR_I,
  input  logic [DW-1:0]   M0_DAT_I,
  input  logic            M0_TGC_I,
  input  logic            M0_TGA_I,
  output logic [DW-1:0]   M0_DAT_O,
  output logic            M0_ACK_O,
  output logic            M0_ERR_O,
  input  logic            M1_CYC_I,
  input  logic            M1_STB_I,
  input  logic            M1_WE_I,
  input  logic [DW/8-1:0] M1_SEL_I,
  input  logic [AW-1:0]   M1_ADR_I,
  input  logic [DW-1:0]   M1_DAT_I,
  input  logic            M1_TGC_I,
  input  logic            M1_TGA_I,
  output logic [DW-1:0]   M1_DAT_O,
  output logic            M1_ACK_O,
  output logic            M1_ERR_O,
  output logic            S_CYC_O,
  output logic            S_STB_O,
  output logic            S_WE_O,
  output logic [DW/8-1:0] S_SEL_O,
  output logic [AW-1:0]   S_ADR_O,
  output logic [DW-1:0]   S_DAT_O,
  output logic            S_TGC_O,
  output logic            S_TGA_O,
  input  logic [DW-1:0]   S_DAT_I,
  input  logic            S_ACK_I,
  input  logic            S_ERR_I,
  output logic [1:0]      GNT_O
);

  if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("wb_arbiter2: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (M0_CYC_I && M1_CYC_I) state_d = last_grant_q ? GRANT0 : GRANT1;
        else if (M0_CYC_I)        state_d = GRANT0;
        else if (M1_CYC_I)        state_d = GRANT1;
      end
      GRANT0: begin
        if (!M0_CYC_I) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      GRANT1: begin
        if (!M1_CYC_I) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          gnt_stb;

  assign gnt_stb = ((state_q == GRANT0) && M0_CYC_I && M0_STB_I) ||
                   ((state_q == GRANT1) && M1_CYC_I && M1_STB_I);
  assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

  // Held at zero in IDLE, so every grant starts with a clean count.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q == IDLE) || S_ACK_I || S_ERR_I || tmo_hit) tmo_cnt_d = '0;
    else if (gnt_stb)                                       tmo_cnt_d = tmo_cnt_q + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign M0_DAT_O = S_DAT_I;
  assign M1_DAT_O = S_DAT_I;

  // Responses are gated with the master's own CYC: a dropped cycle is abandoned.
  always_comb begin
    S_CYC_O  = 1'b0;
    S_STB_O  = 1'b0;
    S_WE_O   = 1'b0;
    S_SEL_O  = '0;
    S_ADR_O  = '0;
    S_DAT_O  = '0;
    S_TGC_O  = 1'b0;
    S_TGA_O  = 1'b0;
    M0_ACK_O = 1'b0;
    M0_ERR_O = 1'b0;
    M1_ACK_O = 1'b0;
    M1_ERR_O = 1'b0;
    GNT_O    = 2'b00;
    case (state_q)
      GRANT0: begin
        S_CYC_O  = M0_CYC_I;
        S_STB_O  = M0_STB_I & ~tmo_hit;
        S_WE_O   = M0_WE_I;
        S_SEL_O  = M0_SEL_I;
        S_ADR_O  = M0_ADR_I;
        S_DAT_O  = M0_DAT_I;
        S_TGC_O  = M0_TGC_I;
        S_TGA_O  = M0_TGA_I;
        M0_ACK_O = S_ACK_I & M0_CYC_I;
        M0_ERR_O = (S_ERR_I | tmo_hit) & M0_CYC_I;
        GNT_O    = 2'b01;
      end
      GRANT1: begin
        S_CYC_O  = M1_CYC_I;
        S_STB_O  = M1_STB_I & ~tmo_hit;
        S_WE_O   = M1_WE_I;
        S_SEL_O  = M1_SEL_I;
        S_ADR_O  = M1_ADR_I;
        S_DAT_O  = M1_DAT_I;
        S_TGC_O  = M1_TGC_I;
        S_TGA_O  = M1_TGA_I;
        M1_ACK_O = S_ACK_I & M1_CYC_I;
        M1_ERR_O = (S_ERR_I | tmo_hit) & M1_CYC_I;
        GNT_O    = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2: directed master transactions, a one-wait-state slave model,
// and a monitor that checks every ACK/ERR against per-master expectation queues.
module tb_wb_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    m_cyc, m_stb, m_we, m_tgc, m_tga;
  logic [SW-1:0] m_sel [2];
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];

  logic [DW-1:0] M0_DAT_O, M1_DAT_O, S_DAT_O, S_DAT_I;
  logic          M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O;
  logic          S_CYC_O, S_STB_O, S_WE_O, S_TGC_O, S_TGA_O;
  logic [SW-1:0] S_SEL_O;
  logic [AW-1:0] S_ADR_O;
  logic          s_ack, s_err;
  logic [1:0]    GNT_O;

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .M0_CYC_I(m_cyc[0]), .M0_STB_I(m_stb[0]), .M0_WE_I(m_we[0]), .M0_SEL_I(m_sel[0]),
    .M0_ADR_I(m_adr[0]), .M0_DAT_I(m_dat[0]), .M0_TGC_I(m_tgc[0]), .M0_TGA_I(m_tga[0]),
    .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O), .M0_ERR_O(M0_ERR_O),
    .M1_CYC_I(m_cyc[1]), .M1_STB_I(m_stb[1]), .M1_WE_I(m_we[1]), .M1_SEL_I(m_sel[1]),
    .M1_ADR_I(m_adr[1]), .M1_DAT_I(m_dat[1]), .M1_TGC_I(m_tgc[1]), .M1_TGA_I(m_tga[1]),
    .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O), .M1_ERR_O(M1_ERR_O),
    .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O), .S_WE_O(S_WE_O), .S_SEL_O(S_SEL_O),
    .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_TGC_O(S_TGC_O), .S_TGA_O(S_TGA_O),
    .S_DAT_I(S_DAT_I), .S_ACK_I(s_ack), .S_ERR_I(s_err), .GNT_O(GNT_O)
  );

  logic [1:0] ackv, errv;
  assign ackv = {M1_ACK_O, M0_ACK_O};
  assign errv = {M1_ERR_O, M0_ERR_O};

  // Slave: read data is 0xC0DE in the upper half and the low address bits below.
  logic err_mode, slave_mute;
  assign S_DAT_I = {16'hC0DE, S_ADR_O[15:0]};
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
    end else if (S_CYC_O && S_STB_O && !s_ack && !s_err && !slave_mute) begin
      s_ack <= !err_mode;
      s_err <= err_mode;
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
    end
  end

  typedef struct {
    logic          err;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus beat for master m; first raises CYC after the next edge, last drops it after ACK/ERR.
  task automatic beat(input int m, input bit first, input bit last, input bit we,
                      input logic [AW-1:0] adr, input logic [DW-1:0] dat, input bit exp_err);
    exp_t e;
    int   n;
    e = '{exp_err, we, adr, dat, 4'hF};
    if (first) begin
      @(posedge clk);
      #1;
    end
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    m_we[m]  = we;
    m_sel[m] = 4'hF;
    m_adr[m] = adr;
    m_dat[m] = we ? dat : '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ackv[m] | errv[m]) && n < 200);
    if (!(ackv[m] | errv[m])) check("beat_wait_bound", 64'(n), 64'(0));
    @(posedge clk);
    #1;
    if (last) begin
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      m_we[m]  = 1'b0;
    end
  endtask

  task automatic gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: every response presented to a master is matched against that master's queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        if (ackv[m] | errv[m]) begin
          exp_t e;
          if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp m%0d: ack=%0b err=%0b with nothing expected", m, ackv[m], errv[m]);
          end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            check("resp_err", 64'(errv[m]), 64'(e.err));
            check("resp_gnt", 64'(GNT_O), (m == 0) ? 64'd1 : 64'd2);
            check("other_quiet", 64'(ackv[1-m] | errv[1-m]), 64'd0);
            check("s_adr", 64'(S_ADR_O), 64'(e.adr));
            check("s_we", 64'(S_WE_O), 64'(e.we));
            check("s_sel", 64'(S_SEL_O), 64'(e.sel));
            check("s_tags", 64'({S_TGC_O, S_TGA_O}), (m == 0) ? 64'd2 : 64'd1);
            if (e.we)        check("s_wdat", 64'(S_DAT_O), 64'(e.dat));
            else if (!e.err) check("m_rdat", (m == 0) ? 64'(M0_DAT_O) : 64'(M1_DAT_O), 64'(e.dat));
          end
        end
      end
    end
  end

  logic [1:0] trace[$];
  logic       trace_en;
  always @(negedge clk) if (trace_en) trace.push_back(GNT_O);

  initial begin
    logic [1:0] vals[$];
    int         lens[$];
    logic [1:0] rr_exp [9];
    int         quiet_hits;
    rr_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    rst = 1'b1; err_mode = 1'b0; slave_mute = 1'b0; trace_en = 1'b0;
    m_cyc = 2'b11; m_stb = '0; m_we = '0;
    m_tgc = 2'b01; m_tga = 2'b10;
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = '0; m_adr[i] = '0; m_dat[i] = '0;
    end

    // Reset holds everything quiet even with both masters requesting.
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt", 64'(GNT_O), 64'd0);
      check("rst_scyc", 64'(S_CYC_O), 64'd0);
      check("rst_resp", 64'({ackv, errv}), 64'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rel_gnt_idle", 64'(GNT_O), 64'd0);
    @(negedge clk);
    check("rel_gnt", 64'(GNT_O), 64'd1);
    check("rel_scyc", 64'(S_CYC_O), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_scyc", 64'(S_CYC_O), 64'd0);
    check("arst_gnt", 64'(GNT_O), 64'd0);
    @(posedge clk); #1 m_cyc = 2'b00;
    @(posedge clk); #1 rst = 1'b0;
    gap();

    // Single M1 write with one-cycle grant latency.
    fork
      beat(1, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_idle_scyc", 64'(S_CYC_O), 64'd0);
        @(negedge clk);
        check("lat_grant_scyc", 64'(S_CYC_O), 64'd1);
        check("lat_grant_gnt", 64'(GNT_O), 64'd2);
      end
    join
    gap();

    // Round robin with both masters re-requesting.
    trace_en = 1'b1;
    fork
      begin
        beat(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'hC0DE0100, 1'b0);
        beat(0, 1'b1, 1'b1, 1'b0, 32'h104, 32'hC0DE0104, 1'b0);
      end
      begin
        beat(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'hC0DE0200, 1'b0);
        beat(1, 1'b1, 1'b1, 1'b0, 32'h204, 32'hC0DE0204, 1'b0);
      end
    join
    gap();
    trace_en = 1'b0;
    foreach (trace[i]) begin
      if (vals.size() == 0 || vals[vals.size()-1] != trace[i]) begin
        vals.push_back(trace[i]);
        lens.push_back(1);
      end else begin
        lens[lens.size()-1]++;
      end
    end
    check("rr_seq_len", 64'(vals.size()), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < vals.size()) check("rr_seq", 64'(vals[i]), 64'(rr_exp[i]));
    end
    for (int i = 2; i <= 6; i += 2) begin
      if (i < lens.size()) check("rr_turnaround", 64'(lens[i]), 64'd1);
    end
    gap();

    // Locked M0 cycle of three beats while M1 waits.
    fork
      begin
        beat(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'hC0DE0020, 1'b0);
        beat(0, 1'b0, 1'b0, 1'b1, 32'h24, 32'h12345678, 1'b0);
        beat(0, 1'b0, 1'b1, 1'b0, 32'h28, 32'hC0DE0028, 1'b0);
        @(negedge clk);
        check("lock_drop_gnt", 64'(GNT_O), 64'd1);
        check("lock_drop_scyc", 64'(S_CYC_O), 64'd0);
        @(negedge clk);
        check("lock_turn_gnt", 64'(GNT_O), 64'd0);
        @(negedge clk);
        check("lock_next_gnt", 64'(GNT_O), 64'd2);
      end
      beat(1, 1'b1, 1'b1, 1'b0, 32'h30, 32'hC0DE0030, 1'b0);
    join
    gap();

    // Slave error on an M0 read.
    err_mode = 1'b1;
    beat(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    err_mode = 1'b0;
    gap();

`ifdef WB_ARB_TIMEOUT_EN
    slave_mute = 1'b1;
    fork
      beat(0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1);
      begin
        int n_stb;
        int n_cyc;
        n_stb = 0;
        n_cyc = 0;
        do begin
          @(negedge clk);
          n_cyc++;
          if (S_STB_O) n_stb++;
        end while (!M0_ERR_O && n_cyc < 50);
        check("tmo_err_seen", 64'(M0_ERR_O), 64'd1);
        check("tmo_stb_cycles", 64'(n_stb), 64'd4);
        check("tmo_stb_low", 64'(S_STB_O), 64'd0);
      end
    join
    slave_mute = 1'b0;
`else
    slave_mute = 1'b1;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h60; m_sel[0] = 4'hF;
    quiet_hits = 0;
    repeat (100) begin
      @(negedge clk);
      if (M0_ERR_O || M0_ACK_O) quiet_hits++;
    end
    check("no_tmo_err", 64'(quiet_hits), 64'd0);
    check("no_tmo_gnt", 64'(GNT_O), 64'd1);
    check("no_tmo_stb", 64'(S_STB_O), 64'd1);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    slave_mute = 1'b0;
`endif
    gap();

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation exceeded bound");
    $fatal(1, "time limit");
  end

endmodule
